// File: rtl/lsu_pkg.sv
// Shared types for the LSU memory sequencer: access sizes, FSM states and the latched slot payload.
package lsu_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned RD_W   = 5;

    localparam logic [SIZE_W-1:0] SZ_BYTE = 2'b00;
    localparam logic [SIZE_W-1:0] SZ_HALF = 2'b01;
    localparam logic [SIZE_W-1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } lsu_seq_state_t;

    typedef struct packed {
        logic              is_load;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [SIZE_W-1:0] size;
        logic              zero_ext;
        logic [RD_W-1:0]   rd;
    } lsu_slot_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for one access: byte enables, store shift-up, load shift-down, misalignment.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]        addr_lo,
    input  logic [SIZE_W-1:0] size,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [3:0]        be,
    output logic [DATA_W-1:0] wdata_sh,
    output logic [DATA_W-1:0] rdata_sh,
    output logic              misalign
);

    always_comb begin
        be       = 4'b0000;
        misalign = 1'b0;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: begin
                be       = 4'b0011 << {addr_lo[1], 1'b0};
                misalign = addr_lo[0];
            end
            SZ_WORD: begin
                be       = 4'hF;
                misalign = (addr_lo != 2'b00);
            end
            default: misalign = 1'b1;
        endcase
    end

    assign wdata_sh = wdata << {addr_lo, 3'b000};
    assign rdata_sh = rdata >> {addr_lo, 3'b000};

endmodule

// File: rtl/lsu_mem_sequencer.sv
// Serialises the valid LSU slots of one bundle onto the single data-memory port in slot order.
module lsu_mem_sequencer
    import lsu_pkg::*;
#(
    parameter int unsigned N_SLOTS = 2,
    parameter int unsigned SLOT_W  = $clog2(N_SLOTS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   bundle_valid,
    output logic                   bundle_ready,
    input  logic [N_SLOTS-1:0]     slot_valid,
    input  logic [N_SLOTS-1:0]     slot_is_load,
    input  logic [32*N_SLOTS-1:0]  slot_addr,
    input  logic [32*N_SLOTS-1:0]  slot_wdata,
    input  logic [2*N_SLOTS-1:0]   slot_size,
    input  logic [N_SLOTS-1:0]     slot_zero_ext,
    input  logic [5*N_SLOTS-1:0]   slot_rd,
    output logic                   stall,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [31:0]            mem_addr,
    output logic [31:0]            mem_wdata,
    output logic [3:0]             mem_be,
    input  logic                   mem_gnt,
    input  logic                   mem_rvalid,
    input  logic [31:0]            mem_rdata,
    output logic                   ld_valid,
    output logic [SLOT_W-1:0]      ld_slot,
    output logic [31:0]            ld_data,
    output logic [1:0]             ld_size,
    output logic                   ld_zero_ext,
    output logic [4:0]             ld_rd,
    output logic                   bundle_done,
    output logic                   misalign_err
);

    lsu_seq_state_t    state;
    lsu_seq_state_t    nxt_state;
    logic [N_SLOTS-1:0] pending_q;
    logic [N_SLOTS-1:0] nxt_pend;
    logic [N_SLOTS-1:0] cur_bit;
    logic [N_SLOTS-1:0] mis;
    logic [SLOT_W-1:0]  cur_q;
    logic [SLOT_W-1:0]  nxt_sel;
    logic               accept;

    lsu_slot_t          in_slot [N_SLOTS];
    lsu_slot_t          slots_q [N_SLOTS];
    lsu_slot_t          src     [N_SLOTS];
    logic [3:0]         be_a    [N_SLOTS];
    logic [DATA_W-1:0]  wsh_a   [N_SLOTS];
    logic [DATA_W-1:0]  rsh_a   [N_SLOTS];

    always_comb begin
        for (int i = 0; i < N_SLOTS; i++) begin
            in_slot[i].is_load  = slot_is_load[i];
            in_slot[i].addr     = slot_addr[32*i +: 32];
            in_slot[i].wdata    = slot_wdata[32*i +: 32];
            in_slot[i].size     = slot_size[2*i +: 2];
            in_slot[i].zero_ext = slot_zero_ext[i];
            in_slot[i].rd       = slot_rd[5*i +: 5];
        end
    end

    // In IDLE the lanes see the incoming bundle so the first request can register on accept.
    always_comb begin
        for (int i = 0; i < N_SLOTS; i++) begin
            src[i] = (state == IDLE) ? in_slot[i] : slots_q[i];
        end
    end

    for (genvar g = 0; g < N_SLOTS; g++) begin : g_lane
        lsu_lane_align u_align (
            .addr_lo  (src[g].addr[1:0]),
            .size     (src[g].size),
            .wdata    (src[g].wdata),
            .rdata    (mem_rdata),
            .be       (be_a[g]),
            .wdata_sh (wsh_a[g]),
            .rdata_sh (rsh_a[g]),
            .misalign (mis[g])
        );
    end

    always_comb begin
        nxt_state = state;
        nxt_pend  = pending_q;
        accept    = 1'b0;
        cur_bit   = N_SLOTS'(1) << cur_q;
        case (state)
            IDLE: begin
                if (bundle_valid) begin
                    accept    = 1'b1;
                    nxt_pend  = slot_valid & ~mis;
                    nxt_state = (|nxt_pend) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    if (src[cur_q].is_load) begin
                        nxt_state = WAIT;
                    end else begin
                        nxt_pend  = pending_q & ~cur_bit;
                        nxt_state = (|nxt_pend) ? ISSUE : DONE;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    nxt_pend  = pending_q & ~cur_bit;
                    nxt_state = (|nxt_pend) ? ISSUE : DONE;
                end
            end
            DONE:    nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
        nxt_sel = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (nxt_pend[i]) nxt_sel = SLOT_W'(i);
        end
    end

    // Outputs are registered from the next state so they align with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pending_q    <= '0;
            cur_q        <= '0;
            for (int i = 0; i < N_SLOTS; i++) slots_q[i] <= '0;
            bundle_ready <= 1'b1;
            stall        <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            ld_valid     <= 1'b0;
            ld_slot      <= '0;
            ld_data      <= '0;
            ld_size      <= '0;
            ld_zero_ext  <= 1'b0;
            ld_rd        <= '0;
            bundle_done  <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            state     <= nxt_state;
            pending_q <= nxt_pend;
            if (accept) begin
                for (int i = 0; i < N_SLOTS; i++) slots_q[i] <= in_slot[i];
            end
            if (nxt_state == ISSUE) cur_q <= nxt_sel;

            bundle_ready <= (nxt_state == IDLE);
            stall        <= (nxt_state != IDLE);
            bundle_done  <= (nxt_state == DONE);
            misalign_err <= accept && (|(slot_valid & mis));

            if (nxt_state == ISSUE) begin
                mem_req   <= 1'b1;
                mem_we    <= ~src[nxt_sel].is_load;
                mem_addr  <= {src[nxt_sel].addr[31:2], 2'b00};
                mem_wdata <= wsh_a[nxt_sel];
                mem_be    <= be_a[nxt_sel];
            end else begin
                mem_req   <= 1'b0;
                mem_we    <= 1'b0;
                mem_addr  <= '0;
                mem_wdata <= '0;
                mem_be    <= '0;
            end

            ld_valid <= (state == WAIT) && mem_rvalid;
            if ((state == WAIT) && mem_rvalid) begin
                ld_slot     <= cur_q;
                ld_data     <= rsh_a[cur_q];
                ld_size     <= src[cur_q].size;
                ld_zero_ext <= src[cur_q].zero_ext;
                ld_rd       <= src[cur_q].rd;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Directed self-checking bench for lsu_mem_sequencer; the bench plays the memory side.
module tb_lsu_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bundle_valid;
    logic        bundle_ready;
    logic [1:0]  slot_valid;
    logic [1:0]  slot_is_load;
    logic [63:0] slot_addr;
    logic [63:0] slot_wdata;
    logic [3:0]  slot_size;
    logic [1:0]  slot_zero_ext;
    logic [9:0]  slot_rd;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        ld_valid;
    logic [0:0]  ld_slot;
    logic [31:0] ld_data;
    logic [1:0]  ld_size;
    logic        ld_zero_ext;
    logic [4:0]  ld_rd;
    logic        bundle_done;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    lsu_mem_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .bundle_valid(bundle_valid), .bundle_ready(bundle_ready),
        .slot_valid(slot_valid), .slot_is_load(slot_is_load),
        .slot_addr(slot_addr), .slot_wdata(slot_wdata), .slot_size(slot_size),
        .slot_zero_ext(slot_zero_ext), .slot_rd(slot_rd),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .ld_valid(ld_valid), .ld_slot(ld_slot), .ld_data(ld_data), .ld_size(ld_size),
        .ld_zero_ext(ld_zero_ext), .ld_rd(ld_rd),
        .bundle_done(bundle_done), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bundle_valid  = 1'b0;
        slot_valid    = '0;
        slot_is_load  = '0;
        slot_addr     = '0;
        slot_wdata    = '0;
        slot_size     = '0;
        slot_zero_ext = '0;
        slot_rd       = '0;
        mem_gnt       = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (bundle_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bundle_ready); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", mem_req); end
        checks++; if (bundle_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bundle_done); end
        rst_n = 1'b1;
        tick();
    endtask

    // Single word store with grant tied high.
    task automatic test_store_word();
        int stall_cnt = 0;
        int req_cnt   = 0;
        int done_cnt  = 0;
        clear_inputs();
        mem_gnt            = 1'b1;
        bundle_valid       = 1'b1;
        slot_valid         = 2'b01;
        slot_addr[31:0]    = 32'h0000_0100;
        slot_wdata[31:0]   = 32'hDEAD_BEEF;
        slot_size[1:0]     = 2'b10;
        tick();
        bundle_valid = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL sw_req got req=%b we=%b exp 1 1", mem_req, mem_we); end
        checks++; if (mem_addr !== 32'h0000_0100) begin errors++; $display("FAIL sw_addr got %h exp 00000100", mem_addr); end
        checks++; if (mem_be !== 4'hF) begin errors++; $display("FAIL sw_be got %h exp f", mem_be); end
        checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wdata got %h exp deadbeef", mem_wdata); end
        checks++; if (bundle_ready !== 1'b0) begin errors++; $display("FAIL sw_ready got %b exp 0", bundle_ready); end
        for (int k = 0; k < 6; k++) begin
            if (stall) stall_cnt++;
            if (mem_req) req_cnt++;
            if (bundle_done) done_cnt++;
            tick();
        end
        mem_gnt = 1'b0;
        checks++; if (stall_cnt != 2) begin errors++; $display("FAIL sw_stall_cycles got %0d exp 2", stall_cnt); end
        checks++; if (req_cnt != 1) begin errors++; $display("FAIL sw_req_cycles got %0d exp 1", req_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL sw_done_pulses got %0d exp 1", done_cnt); end
        checks++; if (bundle_ready !== 1'b1) begin errors++; $display("FAIL sw_ready_after got %b exp 1", bundle_ready); end
    endtask

    // Store byte then load byte to the same address; slot order must be preserved.
    task automatic test_store_then_load();
        clear_inputs();
        mem_gnt            = 1'b1;
        bundle_valid       = 1'b1;
        slot_valid         = 2'b11;
        slot_is_load       = 2'b10;
        slot_addr          = {32'h0000_0203, 32'h0000_0203};
        slot_wdata[31:0]   = 32'h0000_00AB;
        slot_size          = {2'b00, 2'b00};
        slot_rd[9:5]       = 5'd7;
        tick();
        bundle_valid = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL sl_st_req got req=%b we=%b exp 1 1", mem_req, mem_we); end
        checks++; if (mem_be !== 4'b1000) begin errors++; $display("FAIL sl_st_be got %b exp 1000", mem_be); end
        checks++; if (mem_wdata !== 32'hAB00_0000) begin errors++; $display("FAIL sl_st_wdata got %h exp ab000000", mem_wdata); end
        checks++; if (mem_addr !== 32'h0000_0200) begin errors++; $display("FAIL sl_st_addr got %h exp 00000200", mem_addr); end
        tick();
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL sl_ld_req got req=%b we=%b exp 1 0", mem_req, mem_we); end
        checks++; if (mem_be !== 4'b1000) begin errors++; $display("FAIL sl_ld_be got %b exp 1000", mem_be); end
        tick();
        mem_gnt = 1'b0;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL sl_wait_req got %b exp 0", mem_req); end
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hAB00_0000;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        checks++; if (ld_valid !== 1'b1) begin errors++; $display("FAIL sl_ld_valid got %b exp 1", ld_valid); end
        checks++; if (ld_data !== 32'h0000_00AB) begin errors++; $display("FAIL sl_ld_data got %h exp 000000ab", ld_data); end
        checks++; if (ld_slot !== 1'b1) begin errors++; $display("FAIL sl_ld_slot got %b exp 1", ld_slot); end
        checks++; if (ld_size !== 2'b00 || ld_rd !== 5'd7) begin errors++; $display("FAIL sl_ld_meta got size=%b rd=%0d exp 00 7", ld_size, ld_rd); end
        checks++; if (bundle_done !== 1'b1) begin errors++; $display("FAIL sl_done got %b exp 1", bundle_done); end
        tick();
        checks++; if (ld_valid !== 1'b0) begin errors++; $display("FAIL sl_ld_pulse got %b exp 0", ld_valid); end
    endtask

    // Zero-extended half load from the upper half of a word, with a one-cycle grant delay.
    task automatic test_load_half();
        clear_inputs();
        bundle_valid       = 1'b1;
        slot_valid         = 2'b01;
        slot_is_load       = 2'b01;
        slot_addr[31:0]    = 32'h0000_0102;
        slot_size[1:0]     = 2'b01;
        slot_zero_ext      = 2'b01;
        slot_rd[4:0]       = 5'd9;
        tick();
        bundle_valid = 1'b0;
        checks++; if (mem_be !== 4'b1100 || mem_addr !== 32'h0000_0100) begin errors++; $display("FAIL lh_req got be=%b addr=%h exp 1100 00000100", mem_be, mem_addr); end
        mem_gnt = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h8001_0000;
        tick();
        mem_rvalid = 1'b0;
        checks++; if (ld_valid !== 1'b1 || ld_data[15:0] !== 16'h8001) begin errors++; $display("FAIL lh_data got v=%b d=%h exp 1 8001", ld_valid, ld_data); end
        checks++; if (ld_zero_ext !== 1'b1 || ld_rd !== 5'd9 || ld_size !== 2'b01 || ld_slot !== 1'b0) begin
            errors++; $display("FAIL lh_meta got zx=%b rd=%0d size=%b slot=%b exp 1 9 01 0", ld_zero_ext, ld_rd, ld_size, ld_slot);
        end
        tick();
        checks++; if (bundle_ready !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL lh_idle got ready=%b stall=%b exp 1 0", bundle_ready, stall); end
    endtask

    // Misaligned slot1 is dropped while aligned slot0 still issues.
    task automatic test_misalign();
        int req_cnt = 0;
        clear_inputs();
        mem_gnt            = 1'b1;
        bundle_valid       = 1'b1;
        slot_valid         = 2'b11;
        slot_is_load       = 2'b10;
        slot_addr          = {32'h0000_0101, 32'h0000_0050};
        slot_wdata[31:0]   = 32'h0000_0011;
        slot_size          = {2'b10, 2'b00};
        tick();
        bundle_valid = 1'b0;
        checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL ma_err got %b exp 1", misalign_err); end
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h50 || mem_be !== 4'b0001) begin
            errors++; $display("FAIL ma_slot0 got req=%b we=%b addr=%h be=%b exp 1 1 00000050 0001", mem_req, mem_we, mem_addr, mem_be);
        end
        for (int k = 0; k < 4; k++) begin
            if (mem_req) req_cnt++;
            tick();
            if (k == 0) begin
                checks++; if (bundle_done !== 1'b1 || misalign_err !== 1'b0) begin errors++; $display("FAIL ma_done got done=%b err=%b exp 1 0", bundle_done, misalign_err); end
            end
        end
        mem_gnt = 1'b0;
        checks++; if (req_cnt != 1) begin errors++; $display("FAIL ma_req_cycles got %0d exp 1", req_cnt); end
    endtask

    // Grant withheld for five cycles: request must hold steady.
    task automatic test_gnt_stall();
        int bad = 0;
        clear_inputs();
        bundle_valid       = 1'b1;
        slot_valid         = 2'b01;
        slot_addr[31:0]    = 32'h0000_0306;
        slot_wdata[31:0]   = 32'h0000_1234;
        slot_size[1:0]     = 2'b01;
        tick();
        bundle_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0304 || mem_be !== 4'b1100 ||
                mem_wdata !== 32'h1234_0000 || stall !== 1'b1 || bundle_ready !== 1'b0) begin
                errors++; bad++;
                $display("FAIL gs_hold cycle %0d got req=%b addr=%h be=%b wd=%h stall=%b ready=%b", k, mem_req, mem_addr, mem_be, mem_wdata, stall, bundle_ready);
            end
            if (k < 4) tick();
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        checks++; if (mem_req !== 1'b0 || bundle_done !== 1'b1) begin errors++; $display("FAIL gs_release got req=%b done=%b exp 0 1", mem_req, bundle_done); end
        tick();
    endtask

    // Reset asserted while waiting for load data; late rvalid must be ignored.
    task automatic test_reset_in_wait();
        clear_inputs();
        mem_gnt            = 1'b1;
        bundle_valid       = 1'b1;
        slot_valid         = 2'b01;
        slot_is_load       = 2'b01;
        slot_addr[31:0]    = 32'h0000_0400;
        slot_size[1:0]     = 2'b10;
        tick();
        bundle_valid = 1'b0;
        tick();
        mem_gnt = 1'b0;
        checks++; if (mem_req !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL rw_wait got req=%b stall=%b exp 0 1", mem_req, stall); end
        rst_n = 1'b0;
        #1;
        checks++; if (stall !== 1'b0 || bundle_ready !== 1'b1 || mem_req !== 1'b0) begin
            errors++; $display("FAIL rw_async got stall=%b ready=%b req=%b exp 0 1 0", stall, bundle_ready, mem_req);
        end
        tick();
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        tick();
        mem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (ld_valid !== 1'b0) begin errors++; $display("FAIL rw_late_rvalid cycle %0d got %b exp 0", k, ld_valid); end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_store_word();
        test_store_then_load();
        test_load_half();
        test_misalign();
        test_gnt_stall();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_sequencer.md
Name: lsu_mem_sequencer

Overview:
Sequences the load/store slots of one issued VLIW bundle onto the single shared data-memory port.
- Accepts a bundle, then issues each valid slot's memory access one at a time, lowest slot index first (program order within the bundle).
- Generates byte enables and aligns load data down to bit 0.
- Hands each load result to the LSU writeback stage for extension and register write.
- Stalls the front end while a bundle is in flight.

Parameters:
N_SLOTS, 2, LSU slots per bundle.
SLOT_W, 1, width of the slot index, $clog2(N_SLOTS).

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
bundle_valid  in  1  bundle presented.
bundle_ready  out  1  sequencer can accept a bundle.
slot_valid  in  N_SLOTS  per-slot memory op present.
slot_is_load  in  N_SLOTS  1=load, 0=store.
slot_addr  in  32*N_SLOTS  byte address per slot.
slot_wdata  in  32*N_SLOTS  store data, low-aligned.
slot_size  in  2*N_SLOTS  00 byte, 01 half, 10 word.
slot_zero_ext  in  N_SLOTS  unsigned load flag.
slot_rd  in  5*N_SLOTS  load destination register.
stall  out  1  front-end hold.
mem_req  out  1  memory request.
mem_we  out  1  write enable.
mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
mem_wdata  out  32  store data shifted to byte lane.
mem_be  out  4  byte enables.
mem_gnt  in  1  request accepted.
mem_rvalid  in  1  read data valid.
mem_rdata  in  32  read data.
ld_valid  out  1  load result valid (1-cycle pulse).
ld_slot  out  SLOT_W  originating slot.
ld_data  out  32  raw data shifted right by byte offset.
ld_size  out  2  passthrough to writeback.
ld_zero_ext  out  1  passthrough to writeback.
ld_rd  out  5  destination register.
bundle_done  out  1  1-cycle pulse when the bundle has fully completed.
misalign_err  out  1  1-cycle pulse, misaligned slot dropped.

Behaviour:
- Reset (async, any state): state=IDLE, pending mask=0. All outputs 0 except bundle_ready=1. An in-flight request is abandoned; mem_req drops immediately.
- FSM states: IDLE, ISSUE, WAIT, DONE. stall = (state != IDLE). bundle_ready = (state == IDLE).
- IDLE:
  - On bundle_valid: latch all slot fields and set pending = slot_valid with misaligned slots cleared.
  - Misaligned means half with addr[0]=1, word with addr[1:0]!=0, or size 11. Any misaligned valid slot pulses misalign_err the next cycle.
  - pending nonzero -> ISSUE; pending zero -> DONE.
- ISSUE:
  - Select the lowest set pending bit and drive mem_req=1. mem_we, mem_addr, mem_wdata and mem_be are held stable until mem_gnt.
  - mem_be: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<{addr[1],1'b0}; word = 4'hF.
  - mem_wdata = wdata << (8*addr[1:0]).
  - On mem_gnt for a store: clear its pending bit. Next state is ISSUE if bits remain, else DONE.
  - On mem_gnt for a load: go to WAIT, with mem_req=0 in the following cycle.
- WAIT:
  - mem_req=0.
  - On mem_rvalid, in the next cycle: ld_valid=1, ld_data = mem_rdata >> (8*addr[1:0]), plus the slot's size, zero_ext, rd and index.
  - The pending bit is cleared at the same time; go to ISSUE if bits remain, else DONE.
- Rule: mem_rvalid arrives at least 1 cycle after mem_gnt. mem_rvalid outside WAIT is ignored.
- DONE: bundle_done=1 for one cycle, then IDLE. A new bundle can be accepted the cycle after DONE.
- Minimum latency per slot:
  - Store: 1 cycle when mem_gnt is already asserted.
  - Load: 2 cycles plus memory latency.
- A stalled mem_gnt holds ISSUE indefinitely with the request stable.
- A store followed by a load to the same address in the same bundle is ordered by slot index, so the load observes the stored value.

Decomposition:
- Shared package lsu_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state enum lsu_seq_state_t;
  - struct lsu_slot_t {is_load, addr, wdata, size, zero_ext, rd}.
- One sub-module: lsu_lane_align (combinational). Inputs are addr[1:0], size and wdata. Outputs are mem_be, the shifted wdata and the misalign flag. It is reused for load data right-shift.

Test Plan:
1. Slot0 store word 0xDEADBEEF @0x100, slot1 invalid, mem_gnt tied 1 -> one mem_req with be=4'hF and addr 0x100; bundle_done pulses; stall high exactly 2 cycles.
2. Slot0 store byte 0xAB @0x203, slot1 load byte @0x203, rdata=0xAB000000 at 2-cycle latency -> store issued first with be=4'b1000 and wdata=0xAB000000; then ld_valid with ld_data low byte 0xAB, ld_slot=1, size 00.
3. Slot0 load half @0x102 with zero_ext, rdata=0x8001_0000 -> be=4'b1100; ld_data[15:0]=0x8001; ld_zero_ext=1 and ld_rd passed through.
4. Slot1 word load @0x101 -> misalign_err pulse; no mem_req for slot1; bundle_done still pulses.
5. mem_gnt held low 5 cycles -> mem_req and address stable all 5 cycles; stall stays high; bundle_ready=0.
6. Assert rst_n=0 during WAIT -> mem_req=0, stall=0 and bundle_ready=1 immediately; a late mem_rvalid after reset produces no ld_valid.
